// File: rtl/freq_meter_sched.sv
// Round-robin scheduler that time-multiplexes one frequency/duty measurement
// core across N_CH test-clock inputs. It steers the input mux, waits for the
// mux to settle, starts the core, and collects a result or a timeout. Results
// are kept in per-channel registers with a combinational read port.
module freq_meter_sched #(
    parameter int N_CH        = 4,
    parameter int CH_W        = 2,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              run,
    input  logic [N_CH-1:0]   ch_en,
    output logic [CH_W-1:0]   ch_sel,
    output logic              meas_start,
    input  logic              meas_done,
    input  logic [33:0]       meas_freq,
    input  logic [7:0]        meas_duty,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [33:0]       rd_freq,
    output logic [7:0]        rd_duty,
    output logic              rd_valid,
    output logic [N_CH-1:0]   timeout_err,
    output logic              busy,
    output logic              sweep_done
);

    // Timeout counter never narrower than 27 bits; settle counter must hold SETTLE_CYC.
    localparam int TO_LOG = $clog2(TIMEOUT_CYC);
    localparam int TO_W   = (TO_LOG > 27) ? TO_LOG : 27;
    localparam int ST_W   = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_WAIT,
        S_STORE
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [ST_W-1:0]   settle_q, settle_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [33:0]       lat_freq_q, lat_freq_d;
    logic [7:0]        lat_duty_q, lat_duty_d;
    logic              lat_ok_q, lat_ok_d;

    logic [CH_W-1:0]   nxt_from_last;
    logic [CH_W-1:0]   nxt_from_cur;
    logic              sel_ok;

    logic [33:0]       freq_arr [N_CH];
    logic [7:0]        duty_arr [N_CH];
    logic              valid_arr [N_CH];

    // First enabled channel strictly after 'last', wrapping modulo N_CH.
    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] last,
                                                input logic [N_CH-1:0] en);
        logic [CH_W-1:0] r;
        logic            found;
        int              idx;
        r     = last;
        found = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = (int'(last) + i) % N_CH;
            if (!found && en[idx]) begin
                r     = CH_W'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign nxt_from_last = next_ch(last_q, ch_en);
    assign nxt_from_cur  = next_ch(ch_sel_q, ch_en);
    assign sel_ok        = run && (|ch_en);
    assign ch_sel        = ch_sel_q;
    assign busy          = (state_q != S_IDLE);

    // Sequencer next-state and strobes: select, settle, start, wait, store.
    always_comb begin
        state_d    = state_q;
        ch_sel_d   = ch_sel_q;
        last_d     = last_q;
        settle_d   = settle_q;
        to_d       = to_q;
        lat_freq_d = lat_freq_q;
        lat_duty_d = lat_duty_q;
        lat_ok_d   = lat_ok_q;
        meas_start = 1'b0;
        sweep_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_ok) begin
                    ch_sel_d = nxt_from_last;
                    settle_d = '0;
                    state_d  = S_SELECT;
                end
            end
            S_SELECT: begin
                // Counting 0..SETTLE_CYC puts meas_start SETTLE_CYC+1 cycles after ch_sel moves.
                if (settle_q == ST_W'(SETTLE_CYC)) begin
                    state_d = S_START;
                end else begin
                    settle_d = settle_q + ST_W'(1);
                end
            end
            S_START: begin
                meas_start = 1'b1;
                to_d       = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the last allowed cycle still counts as success.
                if (meas_done) begin
                    lat_freq_d = meas_freq;
                    lat_duty_d = meas_duty;
                    lat_ok_d   = 1'b1;
                    state_d    = S_STORE;
                end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    lat_ok_d = 1'b0;
                    state_d  = S_STORE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_STORE: begin
                last_d = ch_sel_q;
                if (sel_ok) begin
                    ch_sel_d = nxt_from_cur;
                    settle_d = '0;
                    state_d  = S_SELECT;
                    if (nxt_from_cur <= ch_sel_q) begin
                        sweep_done = 1'b1;
                    end
                end else begin
                    state_d    = S_IDLE;
                    sweep_done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            ch_sel_q   <= '0;
            last_q     <= CH_W'(N_CH - 1);
            settle_q   <= '0;
            to_q       <= '0;
            lat_freq_q <= '0;
            lat_duty_q <= '0;
            lat_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_sel_q   <= ch_sel_d;
            last_q     <= last_d;
            settle_q   <= settle_d;
            to_q       <= to_d;
            lat_freq_q <= lat_freq_d;
            lat_duty_q <= lat_duty_d;
            lat_ok_q   <= lat_ok_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [33:0] freq_q, freq_d;
            logic [7:0]  duty_q, duty_d;
            logic        valid_q, valid_d;
            logic        terr_q, terr_d;
            logic        wr;

            assign wr = (state_q == S_STORE) && (ch_sel_q == CH_W'(gi));

            // Result update for this channel: success overwrites, timeout clears and flags.
            always_comb begin
                freq_d  = freq_q;
                duty_d  = duty_q;
                valid_d = valid_q;
                terr_d  = terr_q;
                if (wr) begin
                    if (lat_ok_q) begin
                        freq_d  = lat_freq_q;
                        duty_d  = lat_duty_q;
                        valid_d = 1'b1;
                        terr_d  = 1'b0;
                    end else begin
                        freq_d  = '0;
                        duty_d  = '0;
                        valid_d = 1'b0;
                        terr_d  = 1'b1;
                    end
                end
            end

            // Per-channel result registers.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    freq_q  <= '0;
                    duty_q  <= '0;
                    valid_q <= 1'b0;
                    terr_q  <= 1'b0;
                end else begin
                    freq_q  <= freq_d;
                    duty_q  <= duty_d;
                    valid_q <= valid_d;
                    terr_q  <= terr_d;
                end
            end

            assign freq_arr[gi]    = freq_q;
            assign duty_arr[gi]    = duty_q;
            assign valid_arr[gi]   = valid_q;
            assign timeout_err[gi] = terr_q;
        end
    endgenerate

    // Combinational read port; indices beyond the last channel read as zero.
    always_comb begin
        rd_freq  = '0;
        rd_duty  = '0;
        rd_valid = 1'b0;
        if (int'(rd_ch) < N_CH) begin
            rd_freq  = freq_arr[rd_ch];
            rd_duty  = duty_arr[rd_ch];
            rd_valid = valid_arr[rd_ch];
        end
    end

endmodule

// File: doc/freq_meter_sched.md
Name: freq_meter_sched

Overview:
- Time-multiplexes one frequency/duty measurement core across N_CH test-clock inputs.
- Steers the core's input mux (ch_sel), issues a start pulse, and waits for done or timeout.
- Captures freq/duty into per-channel result registers and moves round-robin to the next enabled channel.
- Sits between the clk_test input mux and the measurement core, in the sys_clk (50 MHz) domain.

Parameters:
- N_CH, 4, number of test-clock channels (2..16).
- CH_W, 2, channel index width; must equal clog2(N_CH).
- SETTLE_CYC, 16, sys_clk cycles between a ch_sel change and meas_start (mux/synchroniser settle).
- TIMEOUT_CYC, 100_000_000, sys_clk cycles allowed from meas_start to meas_done (2 s at 50 MHz).

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  asynchronous reset, active low.
- run  in  1  level; 1 = keep sweeping, 0 = stop after the current measurement.
- ch_en  in  N_CH  per-channel enable mask.
- ch_sel  out  CH_W  select for the clk_test mux feeding the core.
- meas_start  out  1  one-cycle start pulse to the core.
- meas_done  in  1  one-cycle pulse from the core; result is valid in the same cycle.
- meas_freq  in  34  measured frequency in Hz.
- meas_duty  in  8  measured duty cycle in percent (0..100).
- rd_ch  in  CH_W  result read index.
- rd_freq  out  34  stored frequency of channel rd_ch (combinational read).
- rd_duty  out  8  stored duty of channel rd_ch.
- rd_valid  out  1  stored valid bit of channel rd_ch.
- timeout_err  out  N_CH  per-channel timeout flags.
- busy  out  1  high in every state except IDLE.
- sweep_done  out  1  one-cycle pulse when a round-robin pass wraps.

Behaviour:
- Reset (async, all outputs and regs): state IDLE, ch_sel=0, meas_start=0, busy=0, sweep_done=0, timeout_err=0, every channel's freq=0, duty=0, valid=0, last-channel pointer=N_CH-1.
- A reset asserted mid-measurement discards the in-flight result; meas_done arriving after reset release while in IDLE is ignored.
- State machine: IDLE -> SELECT -> START -> WAIT -> STORE -> (SELECT | IDLE).
- IDLE:
  - If run=1 and ch_en!=0, pick the next enabled channel strictly after the last-channel pointer, modulo N_CH.
  - Load ch_sel with it and go to SELECT.
- SELECT: count SETTLE_CYC cycles, then go to START.
- START: meas_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
  - meas_start rises exactly SETTLE_CYC+1 cycles after ch_sel updates.
- WAIT:
  - If meas_done=1, latch meas_freq/meas_duty and go to STORE.
  - Else if the counter reaches TIMEOUT_CYC-1, mark a timeout and go to STORE.
  - Done and timeout in the same cycle: done wins.
  - meas_done seen in any other state is ignored.
- STORE (one cycle), on success:
  - channel freq/duty = latched values; valid=1; timeout_err[ch] cleared.
- STORE, on timeout:
  - channel freq=0, duty=0, valid=0; timeout_err[ch] set (sticky until that channel's next success).
- Stored values become visible on rd_* the cycle after STORE.
- After STORE, the last-channel pointer = ch_sel.
  - If run=1 and ch_en!=0, choose the next enabled channel and go to SELECT.
  - Otherwise go to IDLE.
  - sweep_done pulses in the STORE cycle when the chosen next index <= current index, or when returning to IDLE.
- A single enabled channel is re-measured back to back, and sweep_done pulses after every measurement.
- ch_en changing mid-measurement does not abort it: the result is stored even if that channel is now disabled; the mask is sampled only at channel selection.
- run deasserted mid-measurement: the current measurement completes and is stored, then the block goes to IDLE.
- Channel selection wraps N_CH-1 -> 0.
- rd_ch >= N_CH (non-power-of-two N_CH): rd_freq=0, rd_duty=0, rd_valid=0.
- Counters:
  - Timeout counter is 27 bits minimum, sized by clog2(TIMEOUT_CYC); no overflow past TIMEOUT_CYC-1.
  - Settle counter is sized by clog2(SETTLE_CYC+1).

Test Plan:
- Reset release with run=1, ch_en=4'b0001, core model returning 5_000_000 Hz / 50%:
  - ch_sel=0; meas_start 17 cycles after ch_sel load.
  - After done, rd_ch=0 gives rd_freq=5_000_000, rd_duty=50, rd_valid=1; sweep_done pulses each pass.
- ch_en=4'b1011, run=1:
  - measurement order 0,1,3,0,1,3.
  - sweep_done pulses only in the STORE cycle of channel 3.
- Channel 1 core model never returns done, TIMEOUT_CYC=1000:
  - meas_start to STORE takes 1000 cycles; timeout_err=4'b0010; rd_ch=1 gives freq=0, valid=0.
  - Channel 1 then succeeding clears timeout_err[1].
- meas_done asserted on the exact timeout cycle: treated as success, valid=1, timeout_err bit stays 0.
- Mid-measurement disturbances:
  - run dropped while in WAIT: the result is stored, busy falls the cycle after STORE, no new meas_start.
  - ch_en=0 with run=1: stays IDLE, busy=0.
- sys_rst_n pulsed low during WAIT: all outputs are immediately reset values; a late meas_done after release does not write any channel.
